sr_input_conditioner: RTL and testbench
=======================================

# sr_input_conditioner

Synchronizes and debounces two raw, asynchronous push-button inputs (set and reset request) and drives the active-high S/R inputs of the downstream SR latch. It outputs mutually exclusive, fixed-width S or R pulses with a guaranteed idle gap between them, so the latch never sees S=R=1. When presses coincide, R is dominant.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized cycles required to accept a level change; legal range ≥2.
- PULSE_CYCLES, 2: cycles each S or R pulse is held high; legal range ≥1.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- raw_s  input  1  raw set button, asynchronous to clk, active-high.
- raw_r  input  1  raw reset button, asynchronous to clk, active-high.
- S  output  1  set drive to the latch, active-high, registered.
- R  output  1  reset drive to the latch, active-high, registered.
- busy  output  1  high whenever the FSM is not IDLE.
- conflict  output  1  one-cycle pulse when simultaneous S and R requests are resolved.

## Operation
- Reset (rst_n=0, asynchronous): S, R, busy and conflict are 0. Synchronizers, debounced levels, counters and pending flags are 0. State is IDLE.
- Per channel, a 2-flop synchronizer feeds a debouncer. On each edge:
  - If sync ≠ db and cnt == DEBOUNCE_CYCLES-1: db ← sync and cnt ← 0.
  - Else if sync ≠ db: cnt++.
  - Else: cnt ← 0.
  - A bounce shorter than DEBOUNCE_CYCLES clears the count and produces no change.
- A rising edge of db (press) sets pend_s or pend_r on the next edge. Releases are ignored. A press on a channel that is already pending merges into the existing pending flag.
- FSM states: IDLE, DRIVE_S, DRIVE_R, GAP.
  - IDLE with pend_r only: go to DRIVE_R and clear pend_r.
  - IDLE with pend_s only: go to DRIVE_S and clear pend_s.
  - IDLE with both pending: go to DRIVE_R, clear both flags, and pulse conflict for 1 cycle. The S request is discarded.
  - DRIVE_x: S (or R) is high for exactly PULSE_CYCLES cycles, then the FSM moves to GAP.
  - GAP: S=R=0 for exactly 1 cycle, then return to IDLE.
- Requests arriving during DRIVE or GAP are held pending and serviced on the next IDLE evaluation.
- Invariant: S and R are never both 1. Each pulse is followed by at least 1 cycle with both low.
- The pulse counter width is $clog2(PULSE_CYCLES+1). The debounce counter width is $clog2(DEBOUNCE_CYCLES).

## Timing
- Let edge k be the first edge at which raw_s=1 is sampled, with raw_s held stable. Then:
  - sync goes high after edge k+1.
  - db goes high after edge k+1+DEBOUNCE_CYCLES.
  - pend_s is set after edge k+2+DEBOUNCE_CYCLES.
  - S goes high after edge k+3+DEBOUNCE_CYCLES, provided the FSM is IDLE.
- Press-to-drive latency is therefore DEBOUNCE_CYCLES+3 cycles.
- busy rises with S/R and falls 1 cycle after the pulse ends, i.e. stays high for PULSE_CYCLES+1 cycles.
- conflict is high in the same cycle as the first cycle of the resolved R pulse.
- Back-to-back requests: the minimum spacing between pulse starts is PULSE_CYCLES+2 cycles (1 GAP cycle plus 1 IDLE cycle).
- Reset mid-operation: S and R drop immediately (asynchronously). Any pending request is lost. A button still held after reset release must re-debounce and is then a new press, since db restarts at 0.

## Test plan
(All scenarios use DEBOUNCE_CYCLES=4 and PULSE_CYCLES=2.)
- **Reset:** hold rst_n=0 while toggling raw_s/raw_r → S=R=busy=conflict=0 throughout. After release with inputs at 0 → all outputs stay 0.
- **Clean set:** raw_s rises and is first sampled at edge 0, then held → S=1 after edges 7 and 8 and 0 after edge 9. busy is 1 after edges 7–9. R=0 and conflict=0 throughout.
- **Bounce rejection:** raw_s high for 3 cycles then low, repeated twice with 2 low cycles between → S never asserts and busy stays 0.
- **Simultaneous press:** raw_s and raw_r rise at the same edge 0 → R=1 after edges 7–8 and conflict=1 only after edge 7. S stays 0 through edge 20.
- **Staggered press:** raw_s at edge 0, raw_r at edge 1 → S high for edges 7–8 and low for the GAP at 9. pend_r is evaluated in IDLE at edge 10, so R is high for edges 11–12 (spacing 4). conflict=0 and S&R never overlap.
- **Reset mid-pulse:** raw_s held and rst_n pulled low during S high → S falls without waiting for clk. After rst_n release at edge j with raw_s still 1 → a new S pulse starts after edge j+7.

Source files
------------

// File: rtl/sr_input_conditioner.sv
// sr_input_conditioner: synchronises and debounces two raw push-buttons and
// drives mutually exclusive, fixed-width S/R pulses into a downstream SR latch.
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   rst_n    asynchronous active-low reset
//   raw_s    raw set button (asynchronous, active-high)
//   raw_r    raw reset button (asynchronous, active-high)
//   S        set drive to the latch, registered
//   R        reset drive to the latch, registered
//   busy     high whenever the sequencer is not idle
//   conflict one-cycle pulse when coincident requests resolve to R
module sr_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int PULSE_CYCLES    = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_s,
   input  logic raw_r,
   output logic S,
   output logic R,
   output logic busy,
   output logic conflict
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int PC_W = $clog2(PULSE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(PULSE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE_S,
      DRIVE_R,
      GAP
   } state_t;

   // Channel index 0 is the set button, index 1 the reset button.
   logic [1:0]           raw;
   logic [1:0]           meta;
   logic [1:0]           sync;
   logic [1:0]           db;
   logic [1:0]           db_q;
   logic [1:0]           pend;
   logic [1:0]           take;
   logic [1:0][DB_W-1:0] cnt;

   state_t          state_q;
   state_t          state_d;
   logic [PC_W-1:0] pcnt_q;
   logic [PC_W-1:0] pcnt_d;
   logic            conflict_d;

   assign raw = {raw_r, raw_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         sync <= '0;
         db   <= '0;
         db_q <= '0;
         cnt  <= '0;
         pend <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
         db_q <= db;
         // A fresh press is ORed in after the sequencer's consume so it
         // is never lost; a press on a pending channel simply merges.
         pend <= (pend & ~take) | (db & ~db_q);
         for (int i = 0; i < 2; i++) begin
            if (sync[i] != db[i]) begin
               if (cnt[i] == DB_LAST) begin
                  db[i]  <= sync[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + DB_W'(1);
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      pcnt_d     = pcnt_q;
      take       = 2'b00;
      conflict_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            pcnt_d = '0;
            // R dominates: a coincident S request is dropped.
            if (pend[1]) begin
               state_d    = DRIVE_R;
               take       = 2'b11;
               conflict_d = pend[0];
            end else if (pend[0]) begin
               state_d = DRIVE_S;
               take    = 2'b01;
            end
         end
         DRIVE_S, DRIVE_R: begin
            if (pcnt_q == PC_LAST) begin
               state_d = GAP;
            end else begin
               pcnt_d = pcnt_q + PC_W'(1);
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pcnt_q   <= '0;
         S        <= 1'b0;
         R        <= 1'b0;
         conflict <= 1'b0;
      end else begin
         state_q  <= state_d;
         pcnt_q   <= pcnt_d;
         S        <= (state_d == DRIVE_S);
         R        <= (state_d == DRIVE_R);
         conflict <= conflict_d;
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sr_input_conditioner.sv
// tb_sr_input_conditioner: directed and randomized checks of the
// button conditioner against a sample-history reference model.
module tb_sr_input_conditioner;

   localparam int D = 4;
   localparam int P = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic raw_s = 1'b0;
   logic raw_r = 1'b0;
   logic S;
   logic R;
   logic busy;
   logic conflict;

   int vectors = 0;
   int errors  = 0;

   sr_input_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .PULSE_CYCLES(P)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .raw_s(raw_s),
      .raw_r(raw_r),
      .S(S),
      .R(R),
      .busy(busy),
      .conflict(conflict)
   );

   always #5 clk = ~clk;

   // Reference model: a button level is accepted once the same value has
   // been seen on D consecutive synchronised samples (raw samples delayed
   // by two clocks). Pulses are scheduled with a busy timer.
   bit hs[$];
   bit hr[$];
   bit m_db_s, m_db_r;
   bit m_rise_s, m_rise_r;
   bit m_pend_s, m_pend_r;
   bit m_ch_r;
   bit m_conf;
   bit tk_s, tk_r, nd;
   int m_t;

   function automatic bit settled(bit q[$], bit v);
      for (int i = 1; i <= D; i++)
         if (q[i] != v) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_clear();
      hs = {};
      hr = {};
      for (int i = 0; i < D + 2; i++) begin
         hs.push_back(1'b0);
         hr.push_back(1'b0);
      end
      m_db_s = 0; m_db_r = 0;
      m_rise_s = 0; m_rise_r = 0;
      m_pend_s = 0; m_pend_r = 0;
      m_ch_r = 0; m_conf = 0; m_t = 0;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_clear();
      end else begin
         tk_s = 0; tk_r = 0; m_conf = 0;
         if (m_t > 0) begin
            m_t--;
         end else if (m_pend_r) begin
            m_t = P + 1; m_ch_r = 1; tk_r = 1;
            if (m_pend_s) begin tk_s = 1; m_conf = 1; end
         end else if (m_pend_s) begin
            m_t = P + 1; m_ch_r = 0; tk_s = 1;
         end
         m_pend_s = (m_pend_s & ~tk_s) | m_rise_s;
         m_pend_r = (m_pend_r & ~tk_r) | m_rise_r;
         nd = settled(hs, ~m_db_s) ? ~m_db_s : m_db_s;
         m_rise_s = nd & ~m_db_s; m_db_s = nd;
         nd = settled(hr, ~m_db_r) ? ~m_db_r : m_db_r;
         m_rise_r = nd & ~m_db_r; m_db_r = nd;
         hs.push_front(raw_s); void'(hs.pop_back());
         hr.push_front(raw_r); void'(hr.pop_back());
      end
   end

   task automatic chk(string tag, logic got, logic exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      chk("S_model", S, m_t >= 2 && !m_ch_r);
      chk("R_model", R, m_t >= 2 && m_ch_r);
      chk("busy_model", busy, m_t > 0);
      chk("conflict_model", conflict, m_conf);
      chk("no_overlap", S & R, 1'b0);
   endtask

   task automatic quiet(int n);
      raw_s = 0; raw_r = 0;
      for (int i = 0; i < n; i++) step();
   endtask

   int hold_s, hold_r;

   initial begin
      model_clear();
      // reset held while buttons toggle
      for (int i = 0; i < 8; i++) begin
         raw_s = i[0]; raw_r = i[1];
         step();
         chk("rst_S", S, 1'b0);
         chk("rst_busy", busy, 1'b0);
      end
      raw_s = 0; raw_r = 0;
      rst_n = 1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_S", S, 1'b0);
         chk("idle_R", R, 1'b0);
      end

      // clean set: first sampled at edge 0
      raw_s = 1;
      for (int e = 0; e <= 12; e++) begin
         step();
         chk("set_S", S, e == 7 || e == 8);
         chk("set_busy", busy, e >= 7 && e <= 9);
         chk("set_R", R, 1'b0);
         chk("set_conf", conflict, 1'b0);
      end
      quiet(20);

      // bounce rejection
      for (int rep = 0; rep < 2; rep++) begin
         raw_s = 1;
         for (int i = 0; i < 3; i++) begin
            step(); chk("bnc_busy", busy, 1'b0);
         end
         raw_s = 0;
         for (int i = 0; i < 2; i++) begin
            step(); chk("bnc_busy", busy, 1'b0);
         end
      end
      for (int i = 0; i < 12; i++) begin
         step(); chk("bnc_S", S, 1'b0);
      end
      quiet(10);

      // simultaneous press
      raw_s = 1; raw_r = 1;
      for (int e = 0; e <= 20; e++) begin
         step();
         chk("sim_R", R, e == 7 || e == 8);
         chk("sim_conf", conflict, e == 7);
         chk("sim_S", S, 1'b0);
      end
      quiet(20);

      // staggered press
      raw_s = 1;
      for (int e = 0; e <= 16; e++) begin
         step();
         if (e == 0) raw_r = 1;
         chk("stg_S", S, e == 7 || e == 8);
         chk("stg_R", R, e == 11 || e == 12);
         chk("stg_conf", conflict, 1'b0);
      end
      quiet(20);

      // reset in the middle of an S pulse
      raw_s = 1;
      for (int e = 0; e <= 7; e++) step();
      chk("mid_S_hi", S, 1'b1);
      #2 rst_n = 0;
      #1;
      chk("async_S", S, 1'b0);
      chk("async_busy", busy, 1'b0);
      step();
      step();
      rst_n = 1;
      for (int e = 0; e <= 10; e++) begin
         step();
         chk("rel_S", S, e == 7 || e == 8);
      end
      quiet(20);

      // randomized buttons, mixing bounces and real presses
      hold_s = 0; hold_r = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold_s == 0) begin
            raw_s = 1'($urandom_range(0, 1));
            hold_s = $urandom_range(1, 12);
         end else hold_s--;
         if (hold_r == 0) begin
            raw_r = 1'($urandom_range(0, 1));
            hold_r = $urandom_range(1, 12);
         end else hold_r--;
         if (i == 1500) begin
            #2 rst_n = 0;
            #1 chk("rnd_async_S", S, 1'b0);
            chk("rnd_async_R", R, 1'b0);
            step();
            rst_n = 1;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
